// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer sitting directly behind the UART receiver.
// Bytes strobed in on i_rx_valid are stored in a circular FIFO. They are
// presented to the bus side through a first-word-fall-through valid/ready
// port, together with a fill level, a sticky overflow flag and an interrupt.
//
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//   When defined, an idle counter raises the interrupt if bytes sit unread
//   for i_timeout_cycles cycles. When undefined, i_timeout_cycles is unused.
//
// Ports
//   clk              clock
//   rst              asynchronous, active-high reset
//   i_rx_data        byte from the receiver, sampled while i_rx_valid=1
//   i_rx_valid       single-cycle push strobe; the receiver cannot be stalled
//   o_rd_data        head byte; meaningful only while o_rd_valid=1
//   o_rd_valid       FIFO holds at least one byte
//   i_rd_ready       pops the head when o_rd_valid is also set
//   i_flush          synchronous clear of the FIFO contents
//   i_threshold      level interrupt threshold; 0 disables the level interrupt
//   o_level          number of stored bytes, 0..DEPTH
//   o_overflow       sticky flag: a byte was dropped because the FIFO was full
//   i_clr_overflow   clears o_overflow
//   i_timeout_cycles idle timeout length in cycles; 0 disables the timeout
//   o_irq            level-sensitive interrupt request
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    input  logic                  i_flush,
    input  logic [DEPTH_LOG2:0]   i_threshold,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow,
    input  logic [15:0]           i_timeout_cycles,
    output logic                  o_irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [PW-1:0] w_level_d;
    logic          w_timeout_flag;

    // The extra pointer MSB tells full (only MSB differs) from empty (equal).
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[PW-2:0] == r_rptr[PW-2:0]);

    assign w_pop  = !w_empty && i_rd_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push = i_rx_valid && (!w_full || w_pop);
    // A byte arriving during a flush is discarded by the flush, not dropped.
    assign w_drop = i_rx_valid && w_full && !w_pop && !i_flush;

    always_comb begin
        w_level_d = r_level;
        if (i_flush) begin
            w_level_d = '0;
        end else if (w_push && !w_pop) begin
            w_level_d = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_d = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
            r_level <= w_level_d;
            // A drop in the same cycle as the clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_rx_data;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
    logic        r_timeout_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (w_push || w_pop || i_flush || w_empty) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != 16'hFFFF) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
            if (w_pop || i_flush) begin
                r_timeout_flag <= 1'b0;
            end else if ((i_timeout_cycles != 16'd0) && !w_empty &&
                         (r_idle_cnt == i_timeout_cycles)) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign w_timeout_flag = r_timeout_flag;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^i_timeout_cycles;
    assign w_timeout_flag   = 1'b0;
`endif

    assign o_rd_data  = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign o_rd_valid = !w_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_irq      = ((i_threshold != '0) && (r_level >= i_threshold)) || w_timeout_flag;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Randomised self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, DEPTH=16).
// The reference model is a byte queue plus a sticky overflow bit.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        flush;
    logic [4:0]  threshold;
    logic [4:0]  level;
    logic        overflow;
    logic        clr_overflow;
    logic [15:0] timeout_cycles;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;

    uart_rx_fifo #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .o_rd_data        (rd_data),
        .o_rd_valid       (rd_valid),
        .i_rd_ready       (rd_ready),
        .i_flush          (flush),
        .i_threshold      (threshold),
        .o_level          (level),
        .o_overflow       (overflow),
        .i_clr_overflow   (clr_overflow),
        .i_timeout_cycles (timeout_cycles),
        .o_irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Applies one cycle of stimulus, advances the model, samples #1 after the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy,
                         input logic fl, input logic clr);
        int   sz;
        logic pop;
        logic full;
        rx_valid     = v;
        rx_data      = d;
        rd_ready     = rdy;
        flush        = fl;
        clr_overflow = clr;
        sz   = q.size();
        pop  = (sz > 0) && rdy;
        full = (sz == DEPTH);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (v && (!full || pop)) q.push_back(d);
        end
        if (v && full && !pop && !fl) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rd_ready     = 1'b0;
        flush        = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (level !== 5'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d want 0", level);
        end
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_basic();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_rd_valid: got %b want 1", rd_valid);
        end
        n_checks++;
        if (rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL basic_rd_data: got %h want a5", rd_data);
        end
        n_checks++;
        if (level !== 5'd1) begin
            n_fail++; $display("FAIL basic_level: got %0d want 1", level);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain: level %0d valid %b want 0 0", level, rd_valid);
        end
        // Pop attempt while empty must change nothing.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_pop: level %0d valid %b want 0 0", level, rd_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd16) begin
            n_fail++; $display("FAIL ovf_fill_level: got %0d want 16", level);
        end
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            n_fail++; $display("FAIL ovf_set: ovf %b level %0d want 1 16", overflow, level);
        end
        // Drop and clear together: the drop wins.
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: data %h valid %b want %h 1", i, rd_data, rd_valid,
                         8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL ovf_empty: valid %b level %0d want 0 0", rd_valid, level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] head;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        head = q[0];
        n_checks++;
        if (rd_data !== head) begin
            n_fail++; $display("FAIL fpp_head: got %h want %h", rd_data, head);
        end
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_level_ovf: level %0d ovf %b want 16 0", level, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== q[0]) begin
                n_fail++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, rd_data, q[0]);
            end
            if (i == DEPTH - 1) begin
                n_checks++;
                if (rd_data !== 8'h77) begin
                    n_fail++; $display("FAIL fpp_last: got %h want 77", rd_data);
                end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_wrap_random();
        logic v;
        logic r;
        for (int i = 0; i < 240; i++) begin
            // Fill-biased, then drain-biased, then balanced: hits full, empty and wraps.
            if (i < 80) begin
                v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
            end else if (i < 160) begin
                v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
            end else begin
                v = $urandom_range(0, 1) != 0; r = $urandom_range(0, 1) != 0;
            end
            if (q.size() > 0) begin
                n_checks++;
                if (rd_data !== q[0]) begin
                    n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_data, q[0]);
                end
            end
            cycle(v, 8'($urandom), r, 1'b0, ($urandom_range(0, 15) == 0));
            n_checks++;
            if (level !== 5'(q.size()) || rd_valid !== (q.size() != 0) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL wrap_state[%0d]: level %0d valid %b ovf %b want %0d %b %b", i, level,
                         rd_valid, overflow, q.size(), (q.size() != 0), m_ovf);
            end
        end
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_threshold();
        threshold = 5'd4;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 16), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL thr_below: got %b want 0", irq);
        end
        cycle(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL thr_reach: got %b want 1", irq);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL thr_pop: got %b want 0", irq);
        end
        threshold = 5'd0;
        while (q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL thr_zero_full: got %b want 0", irq);
        end
        threshold = 5'd17;
        #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL thr_above_depth: got %b want 0", irq);
        end
        threshold = 5'd16;
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL thr_eq_depth: got %b want 1", irq);
        end
        threshold = 5'd0;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        while (q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (level !== 5'd0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL flush_full: level %0d ovf %b want 0 1", level, overflow);
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (level !== 5'd0 || rd_valid !== 1'b0 || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL flush_push: level %0d valid %b ovf %b want 0 0 %b", level, rd_valid,
                     overflow, m_ovf);
        end
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h3C || level !== 5'd1) begin
            n_fail++; $display("FAIL flush_after: data %h level %0d want 3c 1", rd_data, level);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL flush_cleanup: ovf %b level %0d want 0 0", overflow, level);
        end
    endtask

    task automatic test_timeout();
        logic seen;
        threshold      = 5'd0;
        timeout_cycles = 16'd10;
        cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (irq === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL tmo_early: irq seen %b want 0", seen);
        end
        for (int k = 0; k < 6; k++) begin
            if (!seen) begin
                cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                if (irq === 1'b1) seen = 1'b1;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL tmo_fire: irq seen %b want 1", seen);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL tmo_pop_clear: got %b want 0", irq);
        end
`else
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (irq !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL tmo_disabled: irq seen %b want 0", seen);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
        n_checks++;
        if (level !== 5'd0) begin
            n_fail++; $display("FAIL tmo_level: got %0d want 0", level);
        end
        timeout_cycles = 16'd0;
    endtask

    initial begin
        rst            = 1'b1;
        rx_data        = 8'h00;
        rx_valid       = 1'b0;
        rd_ready       = 1'b0;
        flush          = 1'b0;
        threshold      = 5'd0;
        clr_overflow   = 1'b0;
        timeout_cycles = 16'd0;
        test_reset();
        test_push_basic();
        test_overflow();
        test_full_push_pop();
        test_wrap_random();
        test_threshold();
        test_flush();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
